inst_encoder: RTL

Program-loader block that is the encode side of the core's instruction decoder. It accepts field-level instruction requests (operation, register indices, immediate) over a valid/ready handshake, assembles the RV32I 32-bit instruction word, and writes it into instruction memory at consecutive word addresses. Testbenches and the boot loader use it to fill instruction memory before the core is released from reset.

---
 rtl/inst_encoder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: program-loader front end. Accepts field-level RV32I
// instruction requests over valid/ready, assembles the 32-bit word and
// writes it to instruction memory at consecutive word addresses.
// Optional build macro: INST_ENC_RANGE_CHECK_EN (immediate range checking).
module inst_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_SLLI = 5'd6;
    localparam logic [4:0] OP_SLTI = 5'd7;
    localparam logic [4:0] OP_ORI  = 5'd8;
    localparam logic [4:0] OP_ANDI = 5'd9;
    localparam logic [4:0] OP_BEQ  = 5'd10;
    localparam logic [4:0] OP_BNE  = 5'd11;
    localparam logic [4:0] OP_LUI  = 5'd12;
    localparam logic [4:0] OP_LW   = 5'd13;
    localparam logic [4:0] OP_SW   = 5'd14;
    localparam logic [4:0] OP_JAL  = 5'd15;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_B    = 7'b1100011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STOR = 7'b0100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;

    // The write address equals the number of words written so far.
    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0]       word;
    logic              legal;
    logic              range_bad;
    logic              hs;

    // Assemble the RV32I instruction word from the request fields.
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (in_op)
            OP_ADD:  word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
            OP_SUB:  word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
            OP_SLL:  word = {7'b0000000, in_rs2, in_rs1, 3'b001, in_rd, OPC_R};
            OP_OR:   word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OPC_R};
            OP_XOR:  word = {7'b0000000, in_rs2, in_rs1, 3'b100, in_rd, OPC_R};
            OP_ADDI: word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_I};
            OP_SLLI: word = {7'b0000000, in_imm[4:0], in_rs1, 3'b001, in_rd, OPC_I};
            OP_SLTI: word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_I};
            OP_ORI:  word = {in_imm[11:0], in_rs1, 3'b110, in_rd, OPC_I};
            OP_ANDI: word = {in_imm[11:0], in_rs1, 3'b111, in_rd, OPC_I};
            OP_BEQ:  word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                             in_imm[4:1], in_imm[11], OPC_B};
            OP_BNE:  word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                             in_imm[4:1], in_imm[11], OPC_B};
            OP_LUI:  word = {in_imm[31:12], in_rd, OPC_LUI};
            OP_LW:   word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
            OP_SW:   word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STOR};
            OP_JAL:  word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                             in_rd, OPC_JAL};
            default: legal = 1'b0;
        endcase
    end

`ifdef INST_ENC_RANGE_CHECK_EN
    logic signed [31:0] imm_s;
    assign imm_s = $signed(in_imm);

    // Flag immediates that would not survive truncation into their field.
    always_comb begin
        range_bad = 1'b0;
        case (in_op)
            OP_ADDI, OP_SLTI, OP_ORI, OP_ANDI, OP_LW, OP_SW:
                range_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            OP_SLLI:
                range_bad = |in_imm[31:5];
            OP_BEQ, OP_BNE:
                range_bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
            OP_LUI:
                range_bad = |in_imm[11:0];
            OP_JAL:
                range_bad = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
            default:
                range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    assign hs = in_valid && (state_q == S_LOAD);

    // Session control, write generation and error tracking.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    if (legal && !range_bad) begin
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_W-1:0];
                        wdata_d = word;
                        count_d = count_q + (ADDR_W+1)'(1);
                        if (count_q == LAST_ADDR) state_d = S_FULL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // finish wins over the FULL transition; the accepted word still lands.
                if (finish) state_d = S_IDLE;
            end
            S_FULL: begin
                if (start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (finish) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset drops any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q == S_LOAD);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign err       = err_q;

endmodule
